// File: rtl/p4_router_egress_demux.sv
// p4_router_egress_demux
// Distributes the non-stallable packet stream leaving queue memory onto one
// AXI-Stream output per egress port. Each port owns a word FIFO; a packet is
// admitted at its first word only if that port can still absorb a full MTU,
// so an admitted packet can never overflow and a packet is either forwarded
// whole or dropped whole.
//
// Ports:
//   clk, sresetn          clock, asynchronous active-low reset
//   in_tvalid/tdata/tkeep/tlast/tuser   input word stream (no tready);
//                                       tuser = global queue index, used on
//                                       the first word only
//   out_tvalid/tready/tdata/tkeep/tlast/tuser   per-port output streams;
//                                       tuser = queue index within the port
//   drop_count            per-port packets dropped for lack of space (saturating)
//   bad_queue_count       packets dropped for an out-of-range queue (saturating)
module p4_router_egress_demux #(
  parameter int NUM_EGR_PORTS           = 4,
  parameter int NUM_QUEUES_PER_EGR_PORT = 8,
  parameter int DATA_BYTES              = 64,
  parameter int FIFO_DEPTH              = 64,
  parameter int MTU_BYTES               = 2000,
  localparam int QL = $clog2(NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT),
  localparam int SL = $clog2(NUM_QUEUES_PER_EGR_PORT)
) (
  input  logic                                       clk,
  input  logic                                       sresetn,
  input  logic                                       in_tvalid,
  input  logic [8*DATA_BYTES-1:0]                    in_tdata,
  input  logic [DATA_BYTES-1:0]                      in_tkeep,
  input  logic                                       in_tlast,
  input  logic [QL-1:0]                              in_tuser,
  output logic [NUM_EGR_PORTS-1:0]                   out_tvalid,
  input  logic [NUM_EGR_PORTS-1:0]                   out_tready,
  output logic [NUM_EGR_PORTS-1:0][8*DATA_BYTES-1:0] out_tdata,
  output logic [NUM_EGR_PORTS-1:0][DATA_BYTES-1:0]   out_tkeep,
  output logic [NUM_EGR_PORTS-1:0]                   out_tlast,
  output logic [NUM_EGR_PORTS-1:0][SL-1:0]           out_tuser,
  output logic [NUM_EGR_PORTS-1:0][31:0]             drop_count,
  output logic [31:0]                                bad_queue_count
);

  localparam int DW        = 8 * DATA_BYTES;
  localparam int MTU_WORDS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;
  localparam int EW        = DW + DATA_BYTES + 1 + SL;
  // Highest occupancy (stored + in-flight) at which a full MTU still fits.
  localparam int ADMIT_MAX = FIFO_DEPTH - MTU_WORDS;

  if (NUM_EGR_PORTS < 1 || NUM_QUEUES_PER_EGR_PORT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < MTU_WORDS) begin : g_bad_cfg
    $error("p4_router_egress_demux: FIFO_DEPTH must be a power of two >= MTU_WORDS");
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  typedef enum logic [1:0] {ST_SOP, ST_FWD, ST_DROP} state_t;

  state_t          state;
  logic [PW-1:0]   lat_port;
  logic [SL-1:0]   lat_sub;

  // Input register stage
  logic            reg_vld;
  logic [PW-1:0]   reg_port;
  logic [SL-1:0]   reg_sub;
  logic [DW-1:0]   reg_data;
  logic [DATA_BYTES-1:0] reg_keep;
  logic            reg_last;

  logic [AW:0]     fill [NUM_EGR_PORTS];

  // First-word decode and admission
  logic [QL-1:0]   sop_port_q;
  logic [SL-1:0]   sop_sub;
  logic [PW-1:0]   sop_port;
  logic [PW-1:0]   sop_port_safe;
  logic            sop_in_range;
  logic            sop_fits;
  logic [AW+1:0]   sop_occ;
  logic            in_write;
  logic [PW-1:0]   in_port;
  logic [SL-1:0]   in_sub;

  always_comb begin
    sop_port_q    = QL'(32'(in_tuser) / NUM_QUEUES_PER_EGR_PORT);
    sop_sub       = SL'(32'(in_tuser) % NUM_QUEUES_PER_EGR_PORT);
    sop_in_range  = 32'(sop_port_q) < NUM_EGR_PORTS;
    sop_port      = PW'(sop_port_q);
    sop_port_safe = sop_in_range ? sop_port : '0;
    // The word sitting in the input register is not yet in the FIFO count.
    sop_occ       = (AW+2)'(fill[sop_port_safe]) +
                    (AW+2)'(reg_vld && (reg_port == sop_port_safe));
    sop_fits      = sop_occ <= (AW+2)'(ADMIT_MAX);
    in_write      = in_tvalid && ((state == ST_FWD) ||
                                  (state == ST_SOP && sop_in_range && sop_fits));
    in_port       = (state == ST_SOP) ? sop_port : lat_port;
    in_sub        = (state == ST_SOP) ? sop_sub  : lat_sub;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state           <= ST_SOP;
      lat_port        <= '0;
      lat_sub         <= '0;
      reg_vld         <= 1'b0;
      reg_port        <= '0;
      drop_count      <= '0;
      bad_queue_count <= '0;
    end else begin
      reg_vld <= in_write;
      if (in_write) reg_port <= in_port;
      if (in_tvalid) begin
        case (state)
          ST_SOP: begin
            lat_port <= sop_port;
            lat_sub  <= sop_sub;
            if (!sop_in_range) begin
              bad_queue_count <= sat_inc(bad_queue_count);
              state <= in_tlast ? ST_SOP : ST_DROP;
            end else if (!sop_fits) begin
              drop_count[sop_port_safe] <= sat_inc(drop_count[sop_port_safe]);
              state <= in_tlast ? ST_SOP : ST_DROP;
            end else begin
              state <= in_tlast ? ST_SOP : ST_FWD;
            end
          end
          ST_FWD, ST_DROP: if (in_tlast) state <= ST_SOP;
          default: state <= ST_SOP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_write) begin
      reg_data <= in_tdata;
      reg_keep <= in_tkeep;
      reg_last <= in_tlast;
      reg_sub  <= in_sub;
    end
  end

  // Per-port FIFO and registered output stage
  for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_port
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, we, pop;
    logic          o_vld, o_last;
    logic [DW-1:0] o_data;
    logic [DATA_BYTES-1:0] o_keep;
    logic [SL-1:0] o_sub;

    assign fill[p] = wr_ptr - rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign we      = reg_vld && (reg_port == PW'(p)) && !full;
    // Refill the output register whenever it is empty or being consumed.
    assign pop     = !empty && (!o_vld || out_tready[p]);

    always_ff @(posedge clk) begin
      if (we) mem[wr_ptr[AW-1:0]] <= {reg_data, reg_keep, reg_last, reg_sub};
    end

    always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        o_vld  <= 1'b0;
        o_data <= '0;
        o_keep <= '0;
        o_last <= 1'b0;
        o_sub  <= '0;
      end else begin
        if (we) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          {o_data, o_keep, o_last, o_sub} <= mem[rd_ptr[AW-1:0]];
          o_vld  <= 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end else if (out_tready[p]) begin
          o_vld <= 1'b0;
        end
      end
    end

    assign out_tvalid[p] = o_vld;
    assign out_tdata[p]  = o_data;
    assign out_tkeep[p]  = o_keep;
    assign out_tlast[p]  = o_last;
    assign out_tuser[p]  = o_sub;
  end

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Testbench for p4_router_egress_demux (3 ports so that queue indices 24..31
// are out of range). Expected words are queued per port as stimulus is
// driven; a monitor pops and compares them as the DUT emits, skipping whole
// packets the DUT dropped and tallying those skips against drop_count.
module tb_p4_router_egress_demux;
  localparam int NP = 3, NQ = 8, DB = 64, DEPTH = 64, MTU = 2000;
  localparam int DW = 8 * DB, QL = 5, SL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     sresetn;
  logic                     in_tvalid;
  logic [DW-1:0]            in_tdata;
  logic [DB-1:0]            in_tkeep;
  logic                     in_tlast;
  logic [QL-1:0]            in_tuser;
  logic [NP-1:0]            out_tvalid;
  logic [NP-1:0]            out_tready = '0;
  logic [NP-1:0][DW-1:0]    out_tdata;
  logic [NP-1:0][DB-1:0]    out_tkeep;
  logic [NP-1:0]            out_tlast;
  logic [NP-1:0][SL-1:0]    out_tuser;
  logic [NP-1:0][31:0]      drop_count;
  logic [31:0]              bad_queue_count;

  p4_router_egress_demux #(
    .NUM_EGR_PORTS(NP), .NUM_QUEUES_PER_EGR_PORT(NQ), .DATA_BYTES(DB),
    .FIFO_DEPTH(DEPTH), .MTU_BYTES(MTU)
  ) dut (
    .clk(clk), .sresetn(sresetn),
    .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tuser(in_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser),
    .drop_count(drop_count), .bad_queue_count(bad_queue_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
    logic [SL-1:0] user;
  } word_t;

  word_t expq [NP][$];
  int    pend [NP];
  int    skipped [NP];
  int    words_seen [NP];
  int    lasts_seen [NP];
  bit    in_pkt [NP];
  int    rdy_pct [NP] = '{100, 100, 100};
  int    checks = 0, passed = 0;
  int    pkt_id = 0;
  int    exp_bad = 0;

  // Ready changes just after the active edge so it is stable at the next one.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) out_tready[p] = ($urandom_range(99) < rdy_pct[p]);
  end

  word_t       mw;
  logic [31:0] mon_id;
  always @(negedge clk) begin
    if (sresetn === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (out_tvalid[p] && out_tready[p]) begin
          words_seen[p]++;
          if (out_tlast[p]) lasts_seen[p]++;
          mon_id = out_tdata[p][DW-1 -: 32];
          if (!in_pkt[p]) begin
            while (expq[p].size() > 0 && expq[p][0].data[DW-1 -: 32] != mon_id) begin
              while (expq[p].size() > 0) begin
                mw = expq[p].pop_front();
                if (mw.last) begin pend[p]--; skipped[p]++; break; end
              end
            end
          end
          checks++;
          if (expq[p].size() == 0) begin
            $display("FAIL port%0d_unexpected: got id=%0d idx=%0d, required no output",
                     p, out_tdata[p][DW-1 -: 32], out_tdata[p][DW-33 -: 32]);
          end else begin
            mw = expq[p].pop_front();
            if (mw.last) pend[p]--;
            if ({out_tdata[p], out_tkeep[p], out_tlast[p], out_tuser[p]} !==
                {mw.data, mw.keep, mw.last, mw.user})
              $display("FAIL port%0d_word: got id=%0d idx=%0d last=%0b user=%0d keep=%h, required id=%0d idx=%0d last=%0b user=%0d keep=%h",
                       p, out_tdata[p][DW-1 -: 32], out_tdata[p][DW-33 -: 32], out_tlast[p],
                       out_tuser[p], out_tkeep[p], mw.data[DW-1 -: 32], mw.data[DW-33 -: 32],
                       mw.last, mw.user, mw.keep);
            else passed++;
          end
          in_pkt[p] = !out_tlast[p];
        end
      end
    end
  end

  task automatic drive_word(input int tuser, input int port, input int sub,
                            input int idx, input bit last, input int nb);
    logic [447:0] r;
    word_t w;
    for (int k = 0; k < 14; k++) r[k*32 +: 32] = $urandom;
    @(negedge clk);
    in_tvalid = 1'b1;
    in_tuser  = QL'(tuser);
    in_tdata  = {pkt_id[31:0], idx[31:0], r};
    in_tkeep  = last ? ((64'h1 << nb) - 64'h1) : '1;
    in_tlast  = last;
    if (port >= 0) begin
      w.data = in_tdata; w.keep = in_tkeep; w.last = last; w.user = SL'(sub);
      expq[port].push_back(w);
      if (last) pend[port]++;
    end
  endtask

  task automatic send_pkt(input int q, input int len, input int alt);
    int port;
    pkt_id++;
    port = q / NQ;
    if (port >= NP) begin port = -1; exp_bad++; end
    for (int i = 0; i < len; i++)
      drive_word((i > 0 && alt >= 0) ? alt : q, port, q % NQ, i, i == len - 1,
                 $urandom_range(1, 64));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
    end
  endtask

  task automatic clear_seen();
    for (int p = 0; p < NP; p++) begin words_seen[p] = 0; lasts_seen[p] = 0; end
  endtask

  task automatic test_reset();
    sresetn = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tuser = '0;
    in_tdata = '0; in_tkeep = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_tvalid !== '0) $display("FAIL reset_tvalid: got %b, required 0", out_tvalid); else passed++;
    checks++; if (out_tdata !== '0) $display("FAIL reset_tdata: got nonzero, required 0"); else passed++;
    checks++; if (out_tkeep !== '0) $display("FAIL reset_tkeep: got %h, required 0", out_tkeep); else passed++;
    checks++; if (out_tlast !== '0) $display("FAIL reset_tlast: got %b, required 0", out_tlast); else passed++;
    checks++; if (out_tuser !== '0) $display("FAIL reset_tuser: got %h, required 0", out_tuser); else passed++;
    checks++; if (drop_count !== '0) $display("FAIL reset_drop_count: got %h, required 0", drop_count); else passed++;
    checks++; if (bad_queue_count !== '0) $display("FAIL reset_bad_queue: got %0d, required 0", bad_queue_count); else passed++;
    sresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    rdy_pct = '{100, 100, 100};
    clear_seen();
    pkt_id++;
    drive_word(9, 1, 1, 0, 1'b0, 64);
    drive_word(9, 1, 1, 1, 1'b0, 64);
    checks++; if (out_tvalid !== 3'b000) $display("FAIL single_lat1: got %b, required 000", out_tvalid); else passed++;
    drive_word(9, 1, 1, 2, 1'b1, 17);
    checks++; if (out_tvalid !== 3'b000) $display("FAIL single_lat2: got %b, required 000", out_tvalid); else passed++;
    idle(1);
    checks++; if (out_tvalid !== 3'b010) $display("FAIL single_lat3: got %b, required 010", out_tvalid); else passed++;
    idle(6);
    checks++; if (words_seen[1] !== 3 || lasts_seen[1] !== 1)
      $display("FAIL single_count: got words=%0d lasts=%0d, required 3/1", words_seen[1], lasts_seen[1]); else passed++;
    checks++; if (words_seen[0] + words_seen[2] !== 0)
      $display("FAIL single_other_ports: got %0d words, required 0", words_seen[0] + words_seen[2]); else passed++;
  endtask

  task automatic test_backpressure();
    rdy_pct = '{0, 100, 100};
    idle(2);
    clear_seen();
    for (int k = 0; k < 3; k++) send_pkt(0, 32, -1);
    idle(2);
    checks++; if (drop_count[0] !== 32'd1) $display("FAIL bp_drop_count: got %0d, required 1", drop_count[0]); else passed++;
    checks++; if (out_tvalid[0] !== 1'b1 || words_seen[0] !== 0)
      $display("FAIL bp_held: got valid=%b words=%0d, required 1/0", out_tvalid[0], words_seen[0]); else passed++;
    rdy_pct = '{100, 100, 100};
    idle(120);
    checks++; if (words_seen[0] !== 64 || lasts_seen[0] !== 2)
      $display("FAIL bp_release: got words=%0d lasts=%0d, required 64/2", words_seen[0], lasts_seen[0]); else passed++;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (pend[p] + skipped[p] !== int'(drop_count[p]))
        $display("FAIL bp_drops_port%0d: got missing=%0d, required drop_count=%0d", p, pend[p] + skipped[p], drop_count[p]);
      else passed++;
    end
  endtask

  task automatic test_bad_queue();
    rdy_pct = '{100, 100, 100};
    clear_seen();
    send_pkt(30, 4, -1);
    send_pkt(5, 2, -1);
    send_pkt(25, 1, -1);
    send_pkt(9, 3, -1);
    idle(20);
    checks++; if (bad_queue_count !== exp_bad) $display("FAIL bad_queue_count: got %0d, required %0d", bad_queue_count, exp_bad); else passed++;
    checks++; if (words_seen[0] !== 2 || words_seen[1] !== 3 || words_seen[2] !== 0)
      $display("FAIL bad_queue_words: got %0d/%0d/%0d, required 2/3/0", words_seen[0], words_seen[1], words_seen[2]); else passed++;
  endtask

  task automatic test_tuser_change();
    clear_seen();
    send_pkt(2, 5, 30);
    idle(20);
    checks++; if (words_seen[0] !== 5 || words_seen[1] + words_seen[2] !== 0)
      $display("FAIL tuser_change_words: got %0d/%0d/%0d, required 5/0/0", words_seen[0], words_seen[1], words_seen[2]); else passed++;
  endtask

  task automatic test_random();
    int q;
    rdy_pct = '{90, 60, 25};
    for (int n = 0; n < 800; n++) begin
      q = ($urandom_range(15) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      send_pkt(q, $urandom_range(1, 32), ($urandom_range(3) == 0) ? $urandom_range(0, 31) : -1);
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(2);
    rdy_pct = '{100, 100, 100};
    idle(150);
    checks++; if (bad_queue_count !== exp_bad) $display("FAIL random_bad_queue: got %0d, required %0d", bad_queue_count, exp_bad); else passed++;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (pend[p] + skipped[p] !== int'(drop_count[p]))
        $display("FAIL random_drops_port%0d: got missing=%0d, required drop_count=%0d", p, pend[p] + skipped[p], drop_count[p]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    rdy_pct = '{100, 100, 100};
    pkt_id++;
    drive_word(17, 2, 1, 0, 1'b0, 64);
    drive_word(17, 2, 1, 1, 1'b0, 64);
    drive_word(17, 2, 1, 2, 1'b0, 64);
    #2;
    sresetn = 1'b0;
    in_tvalid = 1'b0;
    #1;
    checks++; if (out_tvalid !== '0) $display("FAIL midreset_tvalid: got %b, required 0", out_tvalid); else passed++;
    checks++; if (out_tdata !== '0) $display("FAIL midreset_tdata: got nonzero, required 0"); else passed++;
    checks++; if (bad_queue_count !== '0 || drop_count !== '0)
      $display("FAIL midreset_counters: got bad=%0d drop=%h, required 0", bad_queue_count, drop_count); else passed++;
    for (int p = 0; p < NP; p++) begin
      expq[p].delete(); pend[p] = 0; skipped[p] = 0; in_pkt[p] = 1'b0;
    end
    exp_bad = 0;
    clear_seen();
    repeat (2) @(negedge clk);
    sresetn = 1'b1;
    idle(1);
    send_pkt(17, 4, -1);
    idle(20);
    checks++; if (words_seen[2] !== 4 || pend[2] !== 0 || drop_count[2] !== 0)
      $display("FAIL midreset_next_pkt: got words=%0d pending=%0d drops=%0d, required 4/0/0",
               words_seen[2], pend[2], drop_count[2]); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bad_queue();
    test_tuser_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
